// File: rtl/pool_window_buf_if.sv
// Stream interface for the 2x2 pooling window buffer: raster pixel input
// with valid/ready, and a 2x2 window output with valid/ready plus frame_done.
interface pool_window_buf_if;
    logic              in_valid;
    logic signed [7:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic              out_ready;
    logic signed [7:0] win0;
    logic signed [7:0] win1;
    logic signed [7:0] win2;
    logic signed [7:0] win3;
    logic              frame_done;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, win0, win1, win2, win3, frame_done
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, win0, win1, win2, win3, frame_done
    );
endinterface

// File: rtl/pool_window_buf.sv
// Collects raster-order conv pixels into non-overlapping 2x2 windows using one
// line buffer for the even row and a single register for the bottom-left pixel.
module pool_window_buf #(
    parameter int IMG_W = 24,
    parameter int IMG_H = 24
) (
    input  logic                clk,
    input  logic                rst,
    pool_window_buf_if.slave    s
);

    localparam int COL_W = (IMG_W > 2) ? $clog2(IMG_W) : 1;
    localparam int ROW_W = (IMG_H > 2) ? $clog2(IMG_H) : 1;

    typedef struct packed {
        logic signed [7:0] tl;
        logic signed [7:0] tr;
        logic signed [7:0] bl;
        logic signed [7:0] br;
    } win_t;

    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic signed [7:0] bl_q, bl_d;
    win_t              win_q, win_d;
    logic              out_valid_q, out_valid_d;
    logic              frame_done_q, frame_done_d;

    logic signed [7:0] line_buf [IMG_W];
    logic [COL_W-1:0]  col_prev;
    logic              in_ready;
    logic              accept;
    logic              col_last;
    logic              row_last;
    logic              buf_we;

    // The only stall source is an unconsumed window still on the output.
    assign in_ready = !out_valid_q || s.out_ready;
    assign accept   = s.in_valid && in_ready;
    assign col_last = (col_q == COL_W'(IMG_W - 1));
    assign row_last = (row_q == ROW_W'(IMG_H - 1));
    assign col_prev = col_q - 1'b1;
    assign buf_we   = accept && !row_q[0];

    always_comb begin
        // NOTE: every variable gets its hold value first so no path through
        // this block leaves one unassigned, which would infer a latch.
        col_d        = col_q;
        row_d        = row_q;
        bl_d         = bl_q;
        win_d        = win_q;
        out_valid_d  = out_valid_q && !s.out_ready;
        frame_done_d = 1'b0;

        if (accept) begin
            if (col_last) begin
                col_d = '0;
                row_d = row_last ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end

            if (row_q[0] && !col_q[0]) begin
                bl_d = s.in_data;
            end

            // Bottom-right pixel completes the window; a fresh load overrides
            // the clear from a consumption on the same edge.
            if (row_q[0] && col_q[0]) begin
                win_d.tl    = line_buf[col_prev];
                win_d.tr    = line_buf[col_q];
                win_d.bl    = bl_q;
                win_d.br    = s.in_data;
                out_valid_d = 1'b1;
            end

            frame_done_d = row_last && col_last;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values computed above, independent of block order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q        <= '0;
            row_q        <= '0;
            bl_q         <= '0;
            win_q        <= '0;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            bl_q         <= bl_d;
            win_q        <= win_d;
            out_valid_q  <= out_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

    // NOTE: the line buffer is deliberately left out of reset; every entry is
    // rewritten on an even row before an odd row can read it.
    always_ff @(posedge clk) begin
        if (buf_we) begin
            line_buf[col_q] <= s.in_data;
        end
    end

    assign s.in_ready   = in_ready;
    assign s.out_valid  = out_valid_q;
    assign s.win0       = win_q.tl;
    assign s.win1       = win_q.tr;
    assign s.win2       = win_q.bl;
    assign s.win3       = win_q.br;
    assign s.frame_done = frame_done_q;

endmodule

// File: tb/tb_pool_window_buf.sv
// Directed bench for pool_window_buf at 4x4: an image-level model predicts the
// window sequence and frame count, and a monitor checks every output cycle.
module tb_pool_window_buf;

    localparam int W = 4;
    localparam int H = 4;
    localparam int N = W * H;

    typedef logic signed [7:0] pix_t;
    typedef struct packed {
        pix_t tl;
        pix_t tr;
        pix_t bl;
        pix_t br;
    } win_t;

    logic clk;
    logic rst;
    pool_window_buf_if bus ();

    pool_window_buf #(.IMG_W(W), .IMG_H(H)) dut (
        .clk (clk),
        .rst (rst),
        .s   (bus)
    );

    int   total;
    int   bad;
    win_t exp_q [$];
    int   exp_fd;
    int   seen_fd;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Every 2x2 block whose bottom-right pixel lies within the first n pixels
    // of the frame yields one window, in raster order of blocks.
    task automatic push_windows(input pix_t pix [N], input int n);
        win_t w;
        for (int br = 0; br < H / 2; br++) begin
            for (int bc = 0; bc < W / 2; bc++) begin
                if ((2 * br + 1) * W + 2 * bc + 1 < n) begin
                    w.tl = pix[2 * br * W + 2 * bc];
                    w.tr = pix[2 * br * W + 2 * bc + 1];
                    w.bl = pix[(2 * br + 1) * W + 2 * bc];
                    w.br = pix[(2 * br + 1) * W + 2 * bc + 1];
                    exp_q.push_back(w);
                end
            end
        end
    endtask

    // Offer one pixel and return 2 time units after the edge that accepts it.
    task automatic send(input pix_t v);
        bit ok;
        int n;
        bus.in_valid = 1'b1;
        bus.in_data  = v;
        n = 0;
        do begin
            @(negedge clk);
            ok = bus.in_ready;
            @(posedge clk);
            #2;
            n++;
        end while (!ok && n < 50);
        if (!ok) check("accept_timeout", 0, 1);
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        bus.in_data  = 8'sh55;
        @(posedge clk);
        #2;
    endtask

    task automatic send_frame(input pix_t pix [N], input bit bubbles);
        push_windows(pix, N);
        exp_fd++;
        for (int i = 0; i < N; i++) begin
            send(pix[i]);
            if (bubbles) idle();
        end
    endtask

    task automatic check_win(input string name, input int a, input int b, input int c, input int d);
        check({name, "_valid"}, int'(bus.out_valid), 1);
        check({name, "_w0"}, int'(bus.win0), a);
        check({name, "_w1"}, int'(bus.win1), b);
        check({name, "_w2"}, int'(bus.win2), c);
        check({name, "_w3"}, int'(bus.win3), d);
    endtask

    // Output monitor: mid-cycle sampling, pops the model on each consumption.
    win_t held_win;
    bit   stalled_prev;
    bit   fd_prev;
    always @(negedge clk) begin
        win_t cur;
        win_t req;
        cur = {bus.win0, bus.win1, bus.win2, bus.win3};
        if (rst) begin
            stalled_prev = 1'b0;
            fd_prev      = 1'b0;
        end else begin
            check("in_ready_rule", int'(bus.in_ready), int'(!bus.out_valid || bus.out_ready));
            if (stalled_prev && bus.out_valid) begin
                check("held_window", int'(cur), int'(held_win));
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_window", 1, 0);
                end else begin
                    req = exp_q.pop_front();
                    total++;
                    if (cur != req) begin
                        bad++;
                        $display("FAIL window: got %h expected %h", cur, req);
                    end
                end
            end
            if (bus.frame_done) begin
                seen_fd++;
                check("fd_with_valid", int'(bus.out_valid), 1);
                check("fd_single_cycle", int'(fd_prev), 0);
            end
            stalled_prev = bus.out_valid && !bus.out_ready;
            held_win     = cur;
            fd_prev      = bus.frame_done;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        pix_t ramp [N];
        pix_t sgn  [N];
        pix_t hi   [N];
        pix_t sgn_init [N] = '{-128, 127, -7, 6, -1, 0, 3, -100,
                               1, 2, 3, 4, -5, -6, -7, -8};

        total   = 0;
        bad     = 0;
        exp_fd  = 0;
        seen_fd = 0;
        for (int i = 0; i < N; i++) begin
            ramp[i] = pix_t'(i);
            hi[i]   = pix_t'(100 + i);
            sgn[i]  = sgn_init[i];
        end

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_frame_done", int'(bus.frame_done), 0);
        check("rst_win0", int'(bus.win0), 0);
        check("rst_win3", int'(bus.win3), 0);
        check("rst_in_ready", int'(bus.in_ready), 1);
        rst = 1'b0;
        idle();

        // Back-to-back frame with exact output timing pinned by literals.
        push_windows(ramp, N);
        exp_fd++;
        for (int i = 0; i < N; i++) begin
            send(ramp[i]);
            if (i == 4) check("even_row_no_valid", int'(bus.out_valid), 0);
            if (i == 5) check_win("win_a", 0, 1, 4, 5);
            if (i == 7) check_win("win_b", 2, 3, 6, 7);
            if (i == 13) check_win("win_c", 8, 9, 12, 13);
            if (i == 15) begin
                check_win("win_d", 10, 11, 14, 15);
                check("fd_after_last", int'(bus.frame_done), 1);
            end
        end
        idle();
        check("fd_cleared", int'(bus.frame_done), 0);
        check("valid_cleared", int'(bus.out_valid), 0);

        // Signed pass-through.
        push_windows(sgn, N);
        exp_fd++;
        for (int i = 0; i < N; i++) begin
            send(sgn[i]);
            if (i == 5) check_win("signed_win", -128, 127, -1, 0);
        end
        idle();

        // Backpressure holds the window and blocks pixel 6.
        push_windows(ramp, N);
        exp_fd++;
        for (int i = 0; i < 6; i++) send(ramp[i]);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = ramp[6];
        repeat (3) begin
            @(posedge clk);
            #2;
        end
        check("bp_in_ready", int'(bus.in_ready), 0);
        check_win("bp_held", 0, 1, 4, 5);
        bus.out_ready = 1'b1;
        for (int i = 6; i < N; i++) begin
            send(ramp[i]);
            if (i == 7) check_win("bp_resume", 2, 3, 6, 7);
        end
        idle();

        // Bubbles between every pixel.
        send_frame(ramp, 1'b1);
        idle();

        // Two frames back-to-back with no gap.
        send_frame(ramp, 1'b0);
        send(hi[0]);
        send(hi[1]);
        send(hi[2]);
        send(hi[3]);
        send(hi[4]);
        send(hi[5]);
        check_win("frame2_first", 100, 101, 104, 105);
        push_windows(hi, N);
        exp_fd++;
        for (int i = 6; i < N; i++) send(hi[i]);
        idle();

        // Reset mid-frame, with a pixel offered during reset.
        push_windows(ramp, 10);
        for (int i = 0; i < 10; i++) send(ramp[i]);
        rst          = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'sd99;
        repeat (2) begin
            @(posedge clk);
            #2;
        end
        check("mid_rst_valid", int'(bus.out_valid), 0);
        check("mid_rst_fd", int'(bus.frame_done), 0);
        check("mid_rst_in_ready", int'(bus.in_ready), 1);
        bus.in_valid = 1'b0;
        rst          = 1'b0;
        idle();
        push_windows(ramp, N);
        exp_fd++;
        for (int i = 0; i < N; i++) begin
            send(ramp[i]);
            if (i == 5) check_win("post_rst_win", 0, 1, 4, 5);
        end
        repeat (3) idle();

        check("windows_left", exp_q.size(), 0);
        check("frame_done_count", seen_fd, exp_fd);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
